// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with write-first bypass and a
// per-register pending scoreboard for RAW hazard detection.
module regfile_mp_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [(1<<ADDR_W)-1:0]   pending
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  clrVec;
  logic [DEPTH-1:0]  setVec;

  // Registers touched by any write port this cycle.
  always_comb begin
    clrVec = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        clrVec[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
  end

  // Register claimed by the instruction issuing this cycle.
  always_comb begin
    setVec = '0;
    if (iss_en && !(HAS_ZERO && iss_addr == '0)) begin
      setVec[iss_addr] = 1'b1;
    end
  end

  // Storage update; later ports overwrite earlier ones on collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] &&
            !(HAS_ZERO && wr_addr[j*ADDR_W +: ADDR_W] == '0)) begin
          regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard: a new producer outranks a retiring one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= setVec | (pending & ~clrVec);
    end
  end

  // Read ports with write-first bypass and busy lookup.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = rd_addr[i*ADDR_W +: ADDR_W];
      d = regs[a];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) begin
          d = wr_data[j*DATA_W +: DATA_W];
        end
      end
      if (HAS_ZERO && a == '0) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i] = 1'b0;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = d;
        rd_busy[i] = pending[a] && !clrVec[a];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench for regfile_mp_scoreboard: directed
// scenarios followed by randomized traffic.
module tb_regfile_mp_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [31:0] pending;

  regfile_mp_scoreboard dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  busy;
    logic [31:0] pend;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int errors = 0;
  int checks = 0;
  int cycle = 0;

  logic [31:0] mem [32];
  logic [31:0] pend;
  bit          known = 0;

  task automatic step(input logic rst, input logic [1:0] we,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic ie, input logic [4:0] ia,
                      input logic [4:0] ra0, input logic [4:0] ra1);
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [4:0]  ra [2];
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    wa[0] = wa0; wa[1] = wa1;
    wd[0] = wd0; wd[1] = wd1;
    ra[0] = ra0; ra[1] = ra1;
    reset = rst; wr_en = we; iss_en = ie; iss_addr = ia;
    wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    rd_addr = {ra1, ra0};
    if (known) begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] d;
        bit hit;
        d = mem[ra[i]];
        hit = 0;
        for (int j = 0; j < 2; j++)
          if (we[j] && wa[j] == ra[i]) begin
            d = wd[j];
            hit = 1;
          end
        if (ra[i] == 0) d = 0;
        e.data[i*32 +: 32] = d;
        e.busy[i] = (ra[i] != 0) && pend[ra[i]] && !hit;
      end
      e.pend = pend;
      e.cyc = cycle;
      expQ.push_back(e);
    end
    if (rst) begin
      for (int r = 0; r < 32; r++) mem[r] = 0;
      pend = 0;
      known = 1;
    end else if (known) begin
      for (int j = 0; j < 2; j++)
        if (we[j]) begin
          if (wa[j] != 0) mem[wa[j]] = wd[j];
          pend[wa[j]] = 1'b0;
        end
      if (ie && ia != 0) pend[ia] = 1'b1;
    end
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, ra0, ra1);
  endtask

  // Monitor: outputs are combinational, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (rd_data[i*32 +: 32] !== e.data[i*32 +: 32]) begin
            errors++;
            $display("FAIL rd_data%0d cyc=%0d got=%h exp=%h", i, e.cyc,
                     rd_data[i*32 +: 32], e.data[i*32 +: 32]);
          end
          checks++;
          if (rd_busy[i] !== e.busy[i]) begin
            errors++;
            $display("FAIL rd_busy%0d cyc=%0d got=%b exp=%b", i, e.cyc,
                     rd_busy[i], e.busy[i]);
          end
        end
        checks++;
        if (pending !== e.pend) begin
          errors++;
          $display("FAIL pending cyc=%0d got=%h exp=%h", e.cyc,
                   pending, e.pend);
        end
      end
    end
  end

  initial begin
    int waitCnt;
    reset = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
    iss_en = 0; iss_addr = 0; rd_addr = 0;
    step(1, 2'b11, 3, 32'h1, 4, 32'h2, 1, 6, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2);
    for (int a = 0; a < 32; a++) idle(5'(a), 5'(31 - a));

    step(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    idle(5, 5);
    step(0, 2'b01, 5, 32'h12345678, 0, 0, 0, 0, 5, 1);
    idle(5, 9);

    step(0, 2'b11, 9, 32'h1, 9, 32'h2, 0, 0, 9, 9);
    idle(9, 5);

    step(0, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    idle(0, 0);

    step(0, 2'b00, 0, 0, 0, 0, 1, 7, 7, 7);
    idle(7, 0);
    step(0, 2'b01, 7, 32'hAA, 0, 0, 0, 0, 7, 7);
    idle(7, 7);
    step(0, 2'b10, 0, 0, 7, 32'hBB, 1, 7, 7, 1);
    idle(7, 7);
    step(0, 2'b01, 7, 32'hCC, 0, 0, 0, 0, 7, 7);

    step(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 4);
    step(0, 2'b01, 4, 32'h55, 0, 0, 0, 0, 3, 4);
    step(1, 2'b01, 4, 32'h66, 0, 0, 1, 8, 3, 4);
    idle(3, 4);
    step(0, 2'b01, 4, 32'h77, 0, 0, 1, 3, 4, 3);
    idle(3, 4);

    for (int n = 0; n < 400; n++) begin
      bit narrow;
      logic [4:0] a [5];
      narrow = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 5; k++)
        a[k] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
           a[0], $urandom, a[1], $urandom,
           ($urandom_range(0, 2) == 0), a[2], a[3], a[4]);
    end
    idle(0, 0);

    waitCnt = 0;
    while (expQ.size() > 0 && waitCnt < 20) begin
      @(posedge clk);
      waitCnt++;
    end
    if (expQ.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain left=%0d", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
- Parametrised multi-port architectural register file for the pipelined datapath. Generalises the single-write, two-read 32x32 file.
- Adds configurable width, depth and port counts, plus same-cycle write-to-read bypass and an optional hard-wired zero register.
- Adds a per-register pending (scoreboard) bit. Decode uses it to detect RAW hazards against in-flight producers.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clock clk.
- rd_addr  input  NUM_RD*ADDR_W  read indices; port i at [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  read data, combinational, bypassed.
- rd_busy  output  NUM_RD  1 = register still awaiting a producer after this cycle's writes.
- wr_en  input  NUM_WR  per-port write enable.
- wr_addr  input  NUM_WR*ADDR_W  write indices.
- wr_data  input  NUM_WR*DATA_W  write data.
- iss_en  input  1  decode issues an instruction that will write iss_addr.
- iss_addr  input  ADDR_W  destination of the issued instruction.
- pending  output  2**ADDR_W  registered scoreboard vector, for debug and stall logic.

Behaviour:
- Reset:
  - On posedge clk with reset=1, all registers clear to 0 and all pending bits clear to 0.
  - wr_en and iss_en are ignored in that cycle.
  - rd_data reflects the zeroed array from the next cycle.
  - Reset mid-operation discards all in-flight pending state.
- Write:
  - On posedge with wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
  - Same-address collision between ports: the highest-index enabled port wins, for both storage and bypass.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read: combinational, zero latency.
  - rd_data[i] = data of the highest-index port j with wr_en[j] && wr_addr[j]==rd_addr[i] (write-first bypass); otherwise reg[rd_addr[i]].
  - With ZERO_REG=1 and rd_addr[i]==0, rd_data[i]=0 regardless of bypass.
  - All read ports are independent; identical addresses on several ports are legal.
- Scoreboard, evaluated per register r each posedge, in priority order:
  1. set = iss_en && iss_addr==r, and not (ZERO_REG && r==0).
  2. clr = any wr_en[j] && wr_addr[j]==r.
  3. pending[r] <= set ? 1 : (clr ? 0 : pending[r]). Set beats clear, because a newer producer is in flight.
- Busy flag: rd_busy[i] = pending[rd_addr[i]] && !clr(rd_addr[i]).
  - Same-cycle writeback un-busies the read because bypass supplies the data.
  - rd_busy ignores same-cycle iss_en, so an instruction never stalls on itself.
  - rd_busy[i]=0 for address 0 when ZERO_REG=1.
- Writes without a prior issue are legal; the pending bit simply stays 0.
- Double issue to a register already pending keeps it pending; the first matching write clears it. Tracking multiple outstanding producers is the issuer's responsibility.
- No X propagation: all outputs are defined for every input combination once reset has been applied.

Test Plan:
- Reset, then read all 32 registers on both ports -> rd_data=0, rd_busy=0, pending=0.
- Write port0 r5=0xDEADBEEF; next cycle rd_addr0=5 -> 0xDEADBEEF. Same-cycle read of r5 while port0 writes 0x12345678 -> 0x12345678 (bypass), and array holds 0x12345678 afterwards.
- Both ports write r9 in one cycle (p0=0x1, p1=0x2) -> bypass read returns 0x2; stored value is 0x2.
- ZERO_REG=1: write r0=0xFFFFFFFF and issue r0 -> rd_data=0, pending[0]=0, rd_busy=0.
- Scoreboard sequence:
  - Issue r7 -> pending[7]=1; read r7 -> rd_busy=1.
  - Write r7=0xAA -> rd_busy=0 in that cycle with rd_data=0xAA; pending[7]=0 next cycle.
  - Issue r7 and write r7 in the same cycle -> pending[7]=1 next cycle.
- Issue r3, write r4=0x55, assert reset for 1 cycle -> all registers 0 and pending all 0, then normal operation resumes.
